// File: rtl/sys_bridge.sv
// CPU-side peripheral bus initiator: decodes word accesses to two timers
// and an interrupt collector, and drives masked pending interrupts to CP0.
module sys_bridge #(
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter logic [31:0] INT_BASE = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [29:0] dev_addr,
  output logic [31:0] dev_din,
  output logic        dev_we0,
  output logic        dev_we1,
  input  logic [31:0] dev_dout0,
  input  logic [31:0] dev_dout1,
  input  logic [5:0]  irq_in,
  output logic [5:0]  hw_int
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    T_TC0,
    T_TC1,
    T_INT,
    T_NONE
  } tgt_t;

  state_t     state;
  tgt_t       tgt;
  tgt_t       dec;
  logic       we_q;
  logic [1:0] off;
  logic [5:0] pending;
  logic [5:0] mask;
  logic [5:0] irq_q;
  logic [5:0] ack;
  logic [31:0] int_rd;
  logic [31:0] rd_mux;
  logic       hit0;
  logic       hit1;
  logic       hit2;
  logic       off_ok;
  logic       int_wr;
  logic       unused_addr;

  assign unused_addr = ^cpu_addr[1:0];
  assign cpu_ready   = (state == IDLE);

  // Offset 3 of every window is a hole
  assign off_ok = (cpu_addr[3:2] != 2'd3);
  assign hit0   = off_ok && (cpu_addr[31:4] == TC0_BASE[31:4]);
  assign hit1   = off_ok && (cpu_addr[31:4] == TC1_BASE[31:4]);
  assign hit2   = off_ok && (cpu_addr[31:4] == INT_BASE[31:4]);

  always_comb begin
    dec = T_NONE;
    unique case (1'b1)
      hit0:    dec = T_TC0;
      hit1:    dec = T_TC1;
      hit2:    dec = T_INT;
      default: dec = T_NONE;
    endcase
  end

  assign int_wr = (state == ISSUE) && we_q && (tgt == T_INT);

  always_comb begin
    int_rd = 32'h0;
    case (off)
      2'd0:    int_rd = {26'h0, pending};
      2'd1:    int_rd = {26'h0, mask};
      default: int_rd = 32'h0;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    if (!we_q) begin
      case (tgt)
        T_TC0:   rd_mux = dev_dout0;
        T_TC1:   rd_mux = dev_dout1;
        T_INT:   rd_mux = int_rd;
        default: rd_mux = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tgt       <= T_NONE;
      we_q      <= 1'b0;
      off       <= 2'd0;
      dev_addr  <= 30'h0;
      dev_din   <= 32'h0;
      dev_we0   <= 1'b0;
      dev_we1   <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'h0;
      mask      <= 6'h0;
    end else begin
      dev_we0  <= 1'b0;
      dev_we1  <= 1'b0;
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            state    <= ISSUE;
            tgt      <= dec;
            we_q     <= cpu_we;
            off      <= cpu_addr[3:2];
            dev_addr <= cpu_addr[31:2];
            dev_din  <= cpu_wdata;
            dev_we0  <= cpu_we && (dec == T_TC0);
            dev_we1  <= cpu_we && (dec == T_TC1);
          end
        end
        ISSUE: begin
          state     <= RESP;
          cpu_done  <= 1'b1;
          cpu_err   <= (tgt == T_NONE);
          cpu_rdata <= rd_mux;
          if (int_wr && off == 2'd1) begin
            mask <= dev_din[5:0];
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A rising edge in the same cycle as an ACK clear keeps the bit set
  assign ack = (int_wr && off == 2'd2) ? dev_din[5:0] : 6'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q   <= 6'h0;
      pending <= 6'h0;
      hw_int  <= 6'h0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~ack) | (irq_in & ~irq_q);
      hw_int  <= pending & mask;
    end
  end

endmodule

// File: tb/tb_sys_bridge.sv
// Directed self-checking bench for sys_bridge.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sys_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [29:0] dev_addr;
  logic [31:0] dev_din;
  logic        dev_we0;
  logic        dev_we1;
  logic [31:0] dev_dout0;
  logic [31:0] dev_dout1;
  logic [5:0]  irq_in;
  logic [5:0]  hw_int;

  int n_vec;
  int n_err;

  logic [31:0] o_rdata;
  logic        o_err;
  int          o_we0;
  int          o_we1;
  int          o_done_at;
  logic [29:0] o_daddr;
  logic [31:0] o_din;
  logic        o_busy;
  logic        o_ready;

  sys_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .dev_addr  (dev_addr),
    .dev_din   (dev_din),
    .dev_we0   (dev_we0),
    .dev_we1   (dev_we1),
    .dev_dout0 (dev_dout0),
    .dev_dout1 (dev_dout1),
    .irq_in    (irq_in),
    .hw_int    (hw_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer models: combinational read data derived from the word address
  assign dev_dout0 = {2'b00, dev_addr} ^ 32'hA5A5_0000;
  assign dev_dout1 = (dev_addr == 30'h1FC5) ? 32'h1234_5678 : 32'hDEAD_0000;

  task automatic access(input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!cpu_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    @(posedge clk);
    o_we0     = 0;
    o_we1     = 0;
    o_done_at = -1;
    o_rdata   = 32'hX;
    o_err     = 1'bX;
    o_daddr   = 30'h0;
    o_din     = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (dev_we0) begin
        o_we0++;
        o_daddr = dev_addr;
        o_din   = dev_din;
      end
      if (dev_we1) o_we1++;
      if (cpu_done) begin
        o_done_at = c;
        o_rdata   = cpu_rdata;
        o_err     = cpu_err;
      end
      if (c == 1) o_busy = !cpu_ready;
      if (c == 3) o_ready = cpu_ready;
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    irq_in    = 6'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cpu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", cpu_ready);
    end
    n_vec++;
    if ({cpu_done, cpu_err, dev_we0, dev_we1} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 0000",
               {cpu_done, cpu_err, dev_we0, dev_we1});
    end
    n_vec++;
    if ({cpu_rdata, dev_din, dev_addr, hw_int} !== 100'h0) begin
      n_err++;
      $display("FAIL reset_data: rdata %h din %h addr %h hw %h want 0",
               cpu_rdata, dev_din, dev_addr, hw_int);
    end
  endtask

  task automatic test_timer_write;
    access(1'b1, 32'h0000_7F00, 32'h0000_0009);
    n_vec++;
    if (o_we0 !== 1 || o_we1 !== 0) begin
      n_err++;
      $display("FAIL wr_strobe: we0 %0d we1 %0d want 1 0", o_we0, o_we1);
    end
    n_vec++;
    if (o_daddr !== 30'h1FC0 || o_din !== 32'h9) begin
      n_err++;
      $display("FAIL wr_bus: addr %h din %h want 1fc0 9", o_daddr, o_din);
    end
    n_vec++;
    if (o_done_at !== 2 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL wr_done: at %0d err %b rd %h want 2 0 0",
               o_done_at, o_err, o_rdata);
    end
    n_vec++;
    if (o_busy !== 1'b1 || o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wr_ready: busy %b ready %b want 1 1", o_busy, o_ready);
    end
  endtask

  task automatic test_timer_read;
    access(1'b0, 32'h0000_7F14, 32'hFFFF_FFFF);
    n_vec++;
    if (o_rdata !== 32'h1234_5678 || o_done_at !== 2 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL rd_tc1: rd %h at %0d err %b want 12345678 2 0",
               o_rdata, o_done_at, o_err);
    end
    n_vec++;
    if (o_we0 + o_we1 !== 0) begin
      n_err++;
      $display("FAIL rd_tc1_strobe: got %0d want 0", o_we0 + o_we1);
    end
    access(1'b0, 32'h0000_7F0B, 32'h0);
    n_vec++;
    if (o_rdata !== 32'hA5A5_1FC2 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL rd_tc0: rd %h err %b want a5a51fc2 0", o_rdata, o_err);
    end
  endtask

  task automatic test_unmapped;
    access(1'b0, 32'h0000_7F0C, 32'h0);
    n_vec++;
    if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_we0 + o_we1 !== 0) begin
      n_err++;
      $display("FAIL unm_rd: err %b rd %h strobes %0d want 1 0 0",
               o_err, o_rdata, o_we0 + o_we1);
    end
    access(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    n_vec++;
    if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_we0 + o_we1 !== 0) begin
      n_err++;
      $display("FAIL unm_wr: err %b rd %h strobes %0d want 1 0 0",
               o_err, o_rdata, o_we0 + o_we1);
    end
    access(1'b1, 32'h0000_7F1C, 32'h1);
    n_vec++;
    if (o_err !== 1'b1 || o_we0 + o_we1 !== 0) begin
      n_err++;
      $display("FAIL unm_hole: err %b strobes %0d want 1 0",
               o_err, o_we0 + o_we1);
    end
  endtask

  task automatic test_irq;
    access(1'b1, 32'h0000_7F24, 32'hFFFF_FF3F);
    access(1'b0, 32'h0000_7F24, 32'h0);
    n_vec++;
    if (o_rdata !== 32'h3F) begin
      n_err++;
      $display("FAIL mask_rd: got %h want 3f", o_rdata);
    end
    irq_in = 6'h02;
    @(negedge clk);
    n_vec++;
    if (hw_int !== 6'h00) begin
      n_err++;
      $display("FAIL irq_lat1: got %h want 00", hw_int);
    end
    @(negedge clk);
    n_vec++;
    if (hw_int !== 6'h02) begin
      n_err++;
      $display("FAIL irq_lat2: got %h want 02", hw_int);
    end
    access(1'b0, 32'h0000_7F20, 32'h0);
    n_vec++;
    if (o_rdata !== 32'h2) begin
      n_err++;
      $display("FAIL pend_rd: got %h want 2", o_rdata);
    end
    access(1'b1, 32'h0000_7F28, 32'h2);
    access(1'b0, 32'h0000_7F20, 32'h0);
    n_vec++;
    if (o_rdata !== 32'h0 || hw_int !== 6'h00) begin
      n_err++;
      $display("FAIL ack_held: pend %h hw %h want 0 00", o_rdata, hw_int);
    end
    access(1'b0, 32'h0000_7F28, 32'h0);
    n_vec++;
    if (o_rdata !== 32'h0 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL ack_rd: got %h err %b want 0 0", o_rdata, o_err);
    end
    irq_in = 6'h00;
    @(negedge clk);
    irq_in = 6'h02;
    repeat (2) @(negedge clk);
    access(1'b0, 32'h0000_7F20, 32'h0);
    n_vec++;
    if (o_rdata !== 32'h2 || hw_int !== 6'h02) begin
      n_err++;
      $display("FAIL irq_reedge: pend %h hw %h want 2 02", o_rdata, hw_int);
    end
    access(1'b1, 32'h0000_7F24, 32'h01);
    @(negedge clk);
    n_vec++;
    if (hw_int !== 6'h00) begin
      n_err++;
      $display("FAIL mask_apply: got %h want 00", hw_int);
    end
    access(1'b1, 32'h0000_7F28, 32'h2);
    irq_in = 6'h00;
  endtask

  task automatic test_ack_race;
    irq_in = 6'h01;
    repeat (2) @(negedge clk);
    irq_in = 6'h00;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_7F28;
    cpu_wdata = 32'h1;
    @(negedge clk);
    cpu_req = 1'b0;
    irq_in  = 6'h01;
    repeat (3) @(negedge clk);
    access(1'b0, 32'h0000_7F20, 32'h0);
    n_vec++;
    if (o_rdata !== 32'h1) begin
      n_err++;
      $display("FAIL ack_race: pend %h want 1", o_rdata);
    end
    access(1'b1, 32'h0000_7F28, 32'h1);
    access(1'b0, 32'h0000_7F20, 32'h0);
    n_vec++;
    if (o_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL ack_plain: pend %h want 0", o_rdata);
    end
    irq_in = 6'h00;
  endtask

  task automatic test_reset_abort;
    int we0n;
    int donen;
    we0n  = 0;
    donen = 0;
    access(1'b1, 32'h0000_7F24, 32'h3F);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_7F00;
    cpu_wdata = 32'h5;
    @(negedge clk);
    cpu_req = 1'b0;
    n_vec++;
    if (dev_we0 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_issue: we0 %b want 1", dev_we0);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (cpu_ready !== 1'b1 || dev_we0 !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: ready %b we0 %b want 1 0",
               cpu_ready, dev_we0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dev_we0) we0n++;
      if (cpu_done) donen++;
    end
    n_vec++;
    if (we0n !== 0 || donen !== 0 || cpu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_after: we0 %0d done %0d ready %b want 0 0 1",
               we0n, donen, cpu_ready);
    end
    access(1'b0, 32'h0000_7F24, 32'h0);
    n_vec++;
    if (o_rdata !== 32'h0 || o_done_at !== 2) begin
      n_err++;
      $display("FAIL abort_mask: got %h at %0d want 0 2", o_rdata, o_done_at);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_timer_write;
    test_timer_read;
    test_unmapped;
    test_irq;
    test_ack_race;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sys_bridge.md
# sys_bridge

CPU-side initiator for the memory-mapped peripheral bus: accepts one word access at a time from the CPU data port, decodes it to timer 0, timer 1 or an internal interrupt collector, drives the timers' register write/read interface, and returns read data with a completion pulse. It also latches device interrupt lines into sticky pending bits and presents the masked result to CP0 as `hw_int`. It sits between the CPU memory stage and the timer instances.

## Interface
- `TC0_BASE`, 32'h0000_7F00: timer 0 base address; window is 12 bytes.
- `TC1_BASE`, 32'h0000_7F10: timer 1 base address; window is 12 bytes.
- `INT_BASE`, 32'h0000_7F20: interrupt collector base address; window is 12 bytes.
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  access request; sampled only while `cpu_ready`=1.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address; bits [1:0] are ignored.
- `cpu_wdata`  in  32  write data.
- `cpu_ready`  out  1  bridge is idle and can accept a request.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  read data; valid while `cpu_done`=1.
- `cpu_err`  out  1  unmapped access; valid while `cpu_done`=1.
- `dev_addr`  out  30  word address to the timers, equal to `cpu_addr[31:2]` of the access.
- `dev_din`  out  32  timer write data.
- `dev_we0`, `dev_we1`  out  1 each  write strobes for timer 0 and timer 1.
- `dev_dout0`, `dev_dout1`  in  32 each  timer read data; combinational from `dev_addr`.
- `irq_in`  in  6  device interrupt lines. Bit 0 is timer 0, bit 1 is timer 1, bits 5:2 are external.
- `hw_int`  out  6  registered value of pending & mask, sent to CP0.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
  - `cpu_ready` = (state == IDLE).
- IDLE: when `cpu_req`=1, the bridge latches addr, we and wdata, decodes the target, and moves to ISSUE.
- Address decode uses word offset `addr[3:2]`, which must be 0..2.
  - An offset of 3 inside any window is unmapped.
  - Any address outside the three windows is unmapped.
- ISSUE lasts exactly one cycle, then moves to RESP.
  - `dev_addr` and `dev_din` carry the latched values.
  - On a write, `dev_we0` or `dev_we1` is 1 for the selected timer only.
  - On a read, the bridge captures the selected source into its read register: `dev_dout0`, `dev_dout1`, or the internal register.
- RESP: `cpu_done`=1 for one cycle, then the FSM returns to IDLE.
  - An unmapped access sets `cpu_err`=1, returns `cpu_rdata`=0, and issues no write strobe.
- `dev_addr` and `dev_din` hold their last value outside ISSUE.
- `cpu_rdata` holds its value until the next RESP.
  - After a write it is 0.
- Interrupt collector registers, word offsets from `INT_BASE`:
  - +0 PENDING: read-only. Reads return {26'b0, pending}. Writes are ignored.
  - +4 MASK: read/write, bits [5:0]. Upper bits of a write are dropped. Reads are zero-extended.
  - +8 ACK: write-1-to-clear on pending. Reads return 0.
- Pending sets on a rising edge of an `irq_in` bit, detected against a registered copy of `irq_in`.
  - A level that is held high does not re-set a bit that was acknowledged.
- If a set and an ACK clear hit the same bit in the same cycle, the set wins.
  - The ACK write takes effect in the ISSUE cycle.
- `hw_int` <= pending & MASK every cycle.

## Timing
- Reset (`reset`=0, asynchronous) forces:
  - state=IDLE and `cpu_ready`=1;
  - `cpu_done`, `cpu_err`, `dev_we0` and `dev_we1` to 0;
  - `cpu_rdata`, `dev_addr` and `dev_din` to 0;
  - pending, MASK, the `irq_in` history and `hw_int` to 0.
- Reset in the middle of an access aborts it. No `cpu_done` is produced and no strobe follows release.
- Request accepted at edge N → strobe is high during cycle N+1 → `cpu_done` is high during cycle N+2 → `cpu_ready` returns in cycle N+3.
- Throughput is one access per 3 cycles.
- `cpu_req` is ignored while `cpu_ready`=0. The requester holds its request until it is accepted.
- Latency from an `irq_in` rising edge to `hw_int` (if unmasked) is 2 cycles: one edge to set pending, one edge for the `hw_int` register.
- A MASK write applies to `hw_int` 1 cycle after the ISSUE cycle.

## Test plan
- Reset, then write 0x0000_0009 to 0x7F00: `dev_we0`=1 for exactly one cycle with `dev_addr`=0x1FC0 and `dev_din`=0x9; `dev_we1` stays 0; `cpu_done` pulses 2 cycles after acceptance with `cpu_err`=0.
- Read 0x7F14 while `dev_dout1`=0x1234_5678 at that address: `cpu_rdata`=0x1234_5678 and `cpu_done`=1 on cycle N+2; no write strobe.
- Read 0x7F0C, then write 0x8000_0000: each returns `cpu_err`=1 and `cpu_rdata`=0, with no strobe asserted.
- Write MASK=0x3F, then pulse `irq_in[1]`:
  - PENDING reads 0x2 and `hw_int`=0x02 two cycles after the edge;
  - writing ACK=0x2 clears it, and `irq_in[1]` held high does not re-set it;
  - a new rising edge sets it again.
- Apply an `irq_in[0]` rising edge in the same cycle as an ACK=0x1 ISSUE: pending bit 0 remains 1.
- Drop `reset` during the ISSUE of a write: after release `cpu_ready`=1, there is no `cpu_done` and no extra `dev_we0` pulse, and MASK reads 0.
